button_pulse_gen: RTL and testbench

Upstream stage of the LED brightness controller. Turns one raw, bouncy, asynchronous push-button into clean single-cycle command pulses. It synchronises the input, debounces it, emits one pulse per press, and emits auto-repeat pulses while the button is held. The brightness controller consumes `button_out` directly and applies one brightness step per pulse. One instance is used per button (plus and minus).

---
 rtl/brightness_pkg.sv | 30 +++
 rtl/button_sync_filter.sv | 65 ++++++
 rtl/button_pulse_gen.sv | 112 +++++++++++
 tb/tb_button_pulse_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/brightness_pkg.sv
// brightness_pkg
// Shared definitions for the LED brightness controller front end:
// button FSM state encoding, default timing constants and a small
// helper used to size counters.
package brightness_pkg;

  // Button FSM state encoding, shared by every block that decodes state.
  localparam logic [1:0] IDLE_ENC      = 2'd0;
  localparam logic [1:0] PRESSED_ENC   = 2'd1;
  localparam logic [1:0] REPEATING_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = IDLE_ENC,
    PRESSED   = PRESSED_ENC,
    REPEATING = REPEATING_ENC
  } btn_state_e;

  // Default timing: 10 ms debounce at a 50 MHz system clock.
  localparam int CLK_HZ                  = 32'd50_000_000;
  localparam int DEBOUNCE_MS             = 32'd10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;
  localparam int DEFAULT_REPEAT_DELAY    = 32'd25_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 32'd5_000_000;

  // Larger of two integers, used for counter sizing.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_sync_filter.sv
// button_sync_filter
// Two-flop synchroniser followed by a debounce counter and a stable level
// register. The stable level flips only after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   button  in   raw asynchronous button level (1 = pressed)
//   stable  out  debounced level (register)
//   rise    out  high during the cycle whose edge flips stable 0 -> 1
//   fall    out  high during the cycle whose edge flips stable 1 -> 0
module button_sync_filter
  import brightness_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          flip_s;

  // rise/fall announce the flip that the next edge commits, so the FSM
  // can register its pulse on the same edge that stable changes. They are
  // decoded from registers only, so nothing from the raw pin leaks through.
  assign flip_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
  assign rise   = flip_s & ~stable_r;
  assign fall   = flip_s & stable_r;
  assign stable = stable_r;

  // Synchroniser, debounce counter and stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        // Any agreement restarts the count, so short glitches never flip.
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= ~stable_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// button_pulse_gen
// Turns one raw push-button into clean single-cycle command pulses: one
// pulse per debounced press, auto-repeat pulses while held, and a pulse on
// each debounced release.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   button       in   raw asynchronous button level (1 = pressed)
//   button_out   out  one-cycle pulse per press and per repeat
//   release_out  out  one-cycle pulse per debounced release
//   pressed      out  debounced stable level
module button_pulse_gen
  import brightness_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_out,
  output logic release_out,
  output logic pressed
);

  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          stable_s;
  logic          rise_s;
  logic          fall_s;
  btn_state_e    state_r;
  logic [RW-1:0] rcnt_r;
  logic          button_out_r;
  logic          release_out_r;

  button_sync_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .stable(stable_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign button_out  = button_out_r;
  assign release_out = release_out_r;
  assign pressed     = stable_s;

  // Press / repeat / release FSM with repeat counter and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rcnt_r        <= '0;
      button_out_r  <= 1'b0;
      release_out_r <= 1'b0;
    end else begin
      button_out_r  <= 1'b0;
      release_out_r <= 1'b0;
      case (state_r)
        IDLE: begin
          rcnt_r <= '0;
          if (rise_s) begin
            state_r      <= PRESSED;
            button_out_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESSED: begin
          // Release is checked first so it beats a coincident repeat expiry.
          if (fall_s) begin
            state_r       <= IDLE;
            release_out_r <= 1'b1;
            rcnt_r        <= '0;
          end else if (!REPEAT_EN) begin
            rcnt_r <= '0;
          end else if (rcnt_r == DELAY_LAST) begin
            state_r      <= REPEATING;
            button_out_r <= 1'b1;
            rcnt_r       <= '0;
          end else begin
            rcnt_r <= rcnt_r + RW'(1);
          end
        end
        REPEATING: begin
          if (fall_s) begin
            state_r       <= IDLE;
            release_out_r <= 1'b1;
            rcnt_r        <= '0;
          end else if (rcnt_r == PERIOD_LAST) begin
            button_out_r <= 1'b1;
            rcnt_r       <= '0;
          end else begin
            rcnt_r <= rcnt_r + RW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          rcnt_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8). Edge 0 is the first non-reset edge of
// each scenario; raw input for edge e is driven before edge e.
module tb_button_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic bout0, rel0, prs0;
  logic bout1, rel1, prs1;

  always #5 clk = ~clk;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_rep (
    .clk(clk), .rst(rst), .button(button),
    .button_out(bout0), .release_out(rel0), .pressed(prs0)
  );

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_norep (
    .clk(clk), .rst(rst), .button(button),
    .button_out(bout1), .release_out(rel1), .pressed(prs1)
  );

  typedef struct packed {
    logic bout;
    logic rel;
    logic prs;
  } exp_t;

  // One scenario: raw-high window [hs,he) (kind 1 prefixes a 20-cycle bounce),
  // reset window [rs,re), pressed windows [a1,b1) and [a2,b2), release edge,
  // and up to six button_out edges (-1 = unused).
  typedef struct {
    string name;
    int    dut;
    int    kind;
    int    len;
    int    hs, he, rs, re;
    int    a1, b1, a2, b2;
    int    rel;
    int    pe[6];
  } case_t;

  case_t cases[6];
  int    n_cases = 0;
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic add_case(input string name, input int dut, input int kind,
                          input int len, input int hs, input int he,
                          input int rs, input int re, input int a1, input int b1,
                          input int a2, input int b2, input int rel,
                          input int p0, input int p1, input int p2,
                          input int p3, input int p4, input int p5);
    case_t c;
    c.name = name; c.dut = dut; c.kind = kind; c.len = len;
    c.hs = hs; c.he = he; c.rs = rs; c.re = re;
    c.a1 = a1; c.b1 = b1; c.a2 = a2; c.b2 = b2; c.rel = rel;
    c.pe[0] = p0; c.pe[1] = p1; c.pe[2] = p2;
    c.pe[3] = p3; c.pe[4] = p4; c.pe[5] = p5;
    cases[n_cases] = c;
    n_cases++;
  endtask

  function automatic logic raw_at(input case_t c, input int e);
    if (c.kind == 1 && e < 20) return ((e / 2) % 2) == 0;
    return (e >= c.hs) && (e < c.he);
  endfunction

  function automatic exp_t exp_at(input case_t c, input int e);
    exp_t x;
    x.bout = 1'b0;
    for (int i = 0; i < 6; i++) if (c.pe[i] == e) x.bout = 1'b1;
    x.rel = (e == c.rel);
    x.prs = ((e >= c.a1) && (e < c.b1)) || ((e >= c.a2) && (e < c.b2));
    if (e >= c.rs && e < c.re) x = '0;
    return x;
  endfunction

  task automatic check(input string nm, input int e, input exp_t got, input exp_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge %0d: got bout/rel/prs=%b required %b", nm, e, got, want);
    end
  endtask

  task automatic apply_reset(input logic btn);
    exp_t g0, g1;
    rst = 1'b1;
    button = btn;
    @(posedge clk);
    #1;
    g0 = {bout0, rel0, prs0};
    g1 = {bout1, rel1, prs1};
    check("reset_rep", -1, g0, 3'b000);
    check("reset_norep", -1, g1, 3'b000);
  endtask

  task automatic run_case(input int idx);
    case_t c;
    exp_t  got, want;
    c = cases[idx];
    for (int e = 0; e < c.len; e++) begin
      rst    = (e >= c.rs) && (e < c.re);
      button = raw_at(c, e);
      exp_q.push_back(exp_at(c, e));
      @(posedge clk);
      #1;
      got  = (c.dut == 0) ? {bout0, rel0, prs0} : {bout1, rel1, prs1};
      want = exp_q.pop_front();
      check(c.name, e, got, want);
      n_tests++;
      if (got.bout && got.rel) begin
        n_fail++;
        $display("FAIL %s_exclusive edge %0d: got bout=1 rel=1 required not both", c.name, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    button = 1'b0;
    add_case("clean_hold", 0, 0,  75, 0,  60, -1, -1, 5,  65, -1, -1, 65,
             5, 25, 33, 41, 49, 57);
    add_case("glitch",     0, 0,  15, 0,   3, -1, -1, -1, -1, -1, -1, -1,
             -1, -1, -1, -1, -1, -1);
    add_case("bounce",     0, 1,  45, 20, 30, -1, -1, 25, 35, -1, -1, 35,
             25, -1, -1, -1, -1, -1);
    add_case("no_repeat",  1, 0, 110, 0, 100, -1, -1, 5, 105, -1, -1, 105,
             5, -1, -1, -1, -1, -1);
    add_case("reset_mid",  0, 0,  50, 0,  50, 30, 35, 5,  30, 40, 50, -1,
             5, 25, 40, -1, -1, -1);
    add_case("short_tap",  0, 0,  15, 0,   4, -1, -1, 5,   9, -1, -1, 9,
             5, -1, -1, -1, -1, -1);

    // Reset held with the button pressed must keep every output low.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) apply_reset(1'b1);

    for (int i = 0; i < n_cases; i++) begin
      apply_reset(1'b0);
      run_case(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
